// File: rtl/inv_cmap_pkg.sv
// rtl/inv_cmap_pkg.sv - shared constants, FSM states and helpers for inverse colour mapping
package inv_cmap_pkg;

   // Channel MSB positions within a {R,G,B} 24-bit word
   localparam int R_MSB = 23;
   localparam int G_MSB = 15;
   localparam int B_MSB = 7;

   // L1 distance width: 3 * 255 = 765 fits in 10 bits
   localparam int DW = 10;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SEARCH = 2'd1,
      ST_DONE   = 2'd2
   } state_t;

   // Absolute difference of two 8-bit channels, zero-extended to DW bits
   function automatic logic [DW-1:0] absdiff8(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] d;
      d = (a >= b) ? (a - b) : (b - a);
      return {2'b00, d};
   endfunction

endpackage

// File: rtl/cmap_dist.sv
// rtl/cmap_dist.sv - combinational L1 distance between two RGB888 words
module cmap_dist
   import inv_cmap_pkg::*;
(
   input  logic [23:0]   i_a,
   input  logic [23:0]   i_b,
   output logic [DW-1:0] o_dist
);

   logic [DW-1:0] w_dr;
   logic [DW-1:0] w_dg;
   logic [DW-1:0] w_db;

   assign w_dr   = absdiff8(i_a[R_MSB -: 8], i_b[R_MSB -: 8]);
   assign w_dg   = absdiff8(i_a[G_MSB -: 8], i_b[G_MSB -: 8]);
   assign w_db   = absdiff8(i_a[B_MSB -: 8], i_b[B_MSB -: 8]);
   assign o_dist = w_dr + w_dg + w_db;

endmodule

// File: rtl/inv_cmap.sv
// rtl/inv_cmap.sv - sequential nearest-palette-entry search for an RGB pixel
module inv_cmap
   import inv_cmap_pkg::*;
#(
   parameter int LGPAL      = 8,
   parameter bit EARLY_EXIT = 1'b1
) (
   input  logic             i_clk,
   input  logic             i_areset_n,
   input  logic             i_wr,
   input  logic [LGPAL-1:0] i_waddr,
   input  logic [23:0]      i_wdata,
   input  logic             i_valid,
   output logic             o_ready,
   input  logic [23:0]      i_pixel,
   output logic             o_valid,
   input  logic             i_ready,
   output logic [LGPAL-1:0] o_index,
   output logic [DW-1:0]    o_dist
);

   localparam int               N    = 1 << LGPAL;
   localparam logic [LGPAL-1:0] LAST = LGPAL'(N - 1);

   state_t           r_state;
   state_t           w_next;
   logic [23:0]      r_pal [N];
   logic [23:0]      r_rdata;
   logic [23:0]      r_pixel;
   logic [LGPAL-1:0] r_raddr;
   logic [LGPAL-1:0] r_rd_idx;
   logic             r_rd_valid;
   logic [LGPAL-1:0] r_best_idx;
   logic [DW-1:0]    r_best_dist;
   logic [LGPAL-1:0] r_index;
   logic [DW-1:0]    r_dist;

   logic [DW-1:0]    w_dist;
   logic             w_accept;
   logic             w_cmp;
   logic             w_better;
   logic             w_finish;
   logic [LGPAL-1:0] w_fin_idx;
   logic [DW-1:0]    w_fin_dist;

   cmap_dist u_dist (
      .i_a    (r_pixel),
      .i_b    (r_rdata),
      .o_dist (w_dist)
   );

   // r_rdata holds entry r_rd_idx once r_rd_valid is set (one cycle after its address)
   assign w_accept   = i_valid && o_ready;
   assign w_cmp      = (r_state == ST_SEARCH) && r_rd_valid;
   assign w_better   = w_dist < r_best_dist;
   assign w_finish   = w_cmp && ((EARLY_EXIT && (w_dist == '0)) || (r_rd_idx == LAST));
   assign w_fin_idx  = w_better ? r_rd_idx : r_best_idx;
   assign w_fin_dist = w_better ? w_dist : r_best_dist;
   assign o_index    = r_index;
   assign o_dist     = r_dist;

   // Palette RAM: unreset so it maps onto block RAM, registered read port
   always_ff @(posedge i_clk) begin
      if (i_wr) begin
         r_pal[i_waddr] <= i_wdata;
      end
      r_rdata <= r_pal[r_raddr];
   end

   // FSM state register
   always_ff @(posedge i_clk or negedge i_areset_n) begin
      if (!i_areset_n) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   // Next-state and handshake outputs
   always_comb begin
      w_next  = r_state;
      o_ready = 1'b0;
      o_valid = 1'b0;
      case (r_state)
         ST_IDLE: begin
            o_ready = 1'b1;
            if (i_valid) begin
               w_next = ST_SEARCH;
            end
         end
         ST_SEARCH: begin
            if (w_finish) begin
               w_next = ST_DONE;
            end
         end
         ST_DONE: begin
            o_valid = 1'b1;
            if (i_ready) begin
               w_next = ST_IDLE;
            end
         end
         default: begin
            w_next = ST_IDLE;
         end
      endcase
   end

   // Search datapath: address sweep, running best, result capture
   always_ff @(posedge i_clk or negedge i_areset_n) begin
      if (!i_areset_n) begin
         r_pixel     <= '0;
         r_raddr     <= '0;
         r_rd_idx    <= '0;
         r_rd_valid  <= 1'b0;
         r_best_idx  <= '0;
         r_best_dist <= '1;
         r_index     <= '0;
         r_dist      <= '0;
      end else if (w_accept) begin
         r_pixel     <= i_pixel;
         r_raddr     <= '0;
         r_rd_valid  <= 1'b0;
         r_best_idx  <= '0;
         r_best_dist <= '1;
      end else if (r_state == ST_SEARCH) begin
         r_rd_valid <= 1'b1;
         r_rd_idx   <= r_raddr;
         if (r_raddr != LAST) begin
            r_raddr <= r_raddr + LGPAL'(1);
         end
         if (w_cmp && w_better) begin
            r_best_idx  <= r_rd_idx;
            r_best_dist <= w_dist;
         end
         if (w_finish) begin
            r_index <= w_fin_idx;
            r_dist  <= w_fin_dist;
         end
      end
   end

endmodule

// File: tb/tb_inv_cmap.sv
// tb/tb_inv_cmap.sv - directed self-checking bench for inv_cmap and cmap_dist
module tb_inv_cmap;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        wr;
   logic [7:0]  waddr;
   logic [23:0] wdata;
   logic [23:0] pixel;
   logic        tvalid;
   logic        tready;
   logic        sel_ee;

   logic        ee_ready, ee_valid, ne_ready, ne_valid;
   logic [7:0]  ee_idx, ne_idx;
   logic [9:0]  ee_dist, ne_dist;

   logic [23:0] da, db;
   logic [9:0]  dd;

   logic        ob_ready, ob_valid;
   logic [7:0]  ob_idx;
   logic [9:0]  ob_dist;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   inv_cmap #(.LGPAL(8), .EARLY_EXIT(1'b1)) u_ee (
      .i_clk      (clk),
      .i_areset_n (rst_n),
      .i_wr       (wr),
      .i_waddr    (waddr),
      .i_wdata    (wdata),
      .i_valid    (tvalid & sel_ee),
      .o_ready    (ee_ready),
      .i_pixel    (pixel),
      .o_valid    (ee_valid),
      .i_ready    (tready),
      .o_index    (ee_idx),
      .o_dist     (ee_dist)
   );

   inv_cmap #(.LGPAL(8), .EARLY_EXIT(1'b0)) u_ne (
      .i_clk      (clk),
      .i_areset_n (rst_n),
      .i_wr       (wr),
      .i_waddr    (waddr),
      .i_wdata    (wdata),
      .i_valid    (tvalid & ~sel_ee),
      .o_ready    (ne_ready),
      .i_pixel    (pixel),
      .o_valid    (ne_valid),
      .i_ready    (tready),
      .o_index    (ne_idx),
      .o_dist     (ne_dist)
   );

   cmap_dist u_dist (
      .i_a    (da),
      .i_b    (db),
      .o_dist (dd)
   );

   assign ob_ready = sel_ee ? ee_ready : ne_ready;
   assign ob_valid = sel_ee ? ee_valid : ne_valid;
   assign ob_idx   = sel_ee ? ee_idx   : ne_idx;
   assign ob_dist  = sel_ee ? ee_dist  : ne_dist;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic wr_pal(input int a, input logic [23:0] d);
      wr    = 1'b1;
      waddr = a[7:0];
      wdata = d;
      step();
      wr    = 1'b0;
   endtask

   task automatic run_px(input logic ee, input logic [23:0] px, input int hold,
                         input logic [7:0] e_idx, input logic [9:0] e_dist,
                         input int e_lat, input string tag);
      int n;
      sel_ee = ee;
      pixel  = px;
      #1;
      chk({tag, " ready_before"}, 32'(ob_ready), 32'd1);
      tvalid = 1'b1;
      step();
      tvalid = 1'b0;
      pixel  = ~px;
      n = 0;
      while (!ob_valid && n < 400) begin
         step();
         n++;
      end
      chk({tag, " latency"}, 32'(n), 32'(e_lat));
      chk({tag, " index"}, 32'(ob_idx), 32'(e_idx));
      chk({tag, " dist"}, 32'(ob_dist), 32'(e_dist));
      for (int i = 0; i < hold; i++) begin
         tvalid = 1'b1;
         step();
         chk({tag, " hold"}, 32'({ob_valid, ob_ready, ob_idx, ob_dist}),
             32'({1'b1, 1'b0, e_idx, e_dist}));
      end
      tvalid = 1'b0;
      tready = 1'b1;
      step();
      tready = 1'b0;
      chk({tag, " handshake"}, 32'({ob_valid, ob_ready}), 32'(2'b01));
   endtask

   task automatic load_ramp();
      int j;
      int sq;
      for (int i = 0; i < 256; i++) begin
         j  = i - 1;
         sq = (j * j) >> 8;
         if (i == 0) wr_pal(i, 24'h000000);
         else        wr_pal(i, {j[7:0], j[7:0], sq[7:0]});
      end
   endtask

   initial begin
      rst_n  = 1'b0;
      wr     = 1'b0;
      waddr  = '0;
      wdata  = '0;
      pixel  = '0;
      tvalid = 1'b0;
      tready = 1'b0;
      sel_ee = 1'b0;
      da     = '0;
      db     = '0;
      repeat (3) step();

      chk("rst ee_ready", 32'(ee_ready), 32'd1);
      chk("rst ee_valid", 32'(ee_valid), 32'd0);
      chk("rst ee_idx",   32'(ee_idx),   32'd0);
      chk("rst ee_dist",  32'(ee_dist),  32'd0);
      chk("rst ne_ready", 32'(ne_ready), 32'd1);
      chk("rst ne_valid", 32'(ne_valid), 32'd0);
      rst_n = 1'b1;
      step();

      da = 24'h000000; db = 24'hFFFFFF; #1;
      chk("dist max", 32'(dd), 32'd765);
      da = 24'h102030; db = 24'h201003; #1;
      chk("dist mixed", 32'(dd), 32'd77);
      da = 24'hABCDEF; db = 24'hABCDEF; #1;
      chk("dist zero", 32'(dd), 32'd0);
      da = 24'hFF0001; db = 24'h00FF00; #1;
      chk("dist swap", 32'(dd), 32'd511);

      load_ramp();
      run_px(1'b1, 24'h3F3F0F, 20, 8'd64, 10'd0, 66, "exact_ee");
      run_px(1'b0, 24'h808045, 0, 8'd129, 10'd5, 257, "near_ne");
      run_px(1'b1, 24'h808045, 0, 8'd129, 10'd5, 257, "near_ee");

      sel_ee = 1'b0;
      pixel  = 24'h3F3F0F;
      tvalid = 1'b1;
      step();
      tvalid = 1'b0;
      repeat (102) step();
      rst_n = 1'b0;
      #1;
      chk("midrst valid", 32'(ne_valid), 32'd0);
      chk("midrst ready", 32'(ne_ready), 32'd1);
      chk("midrst idx",   32'(ne_idx),   32'd0);
      chk("midrst dist",  32'(ne_dist),  32'd0);
      step();
      rst_n = 1'b1;
      step();
      run_px(1'b0, 24'h808045, 0, 8'd129, 10'd5, 257, "after_rst_ne");

      for (int i = 0; i < 256; i++) begin
         wr_pal(i, (i == 5 || i == 9) ? 24'h101010 : 24'hFFFFFF);
      end
      run_px(1'b0, 24'h101010, 0, 8'd5, 10'd0, 257, "tie_ne");
      run_px(1'b1, 24'h101010, 0, 8'd5, 10'd0, 7, "tie_ee");

      for (int i = 0; i < 256; i++) begin
         wr_pal(i, (i == 200) ? 24'hFFFFFF : 24'h000000);
      end
      run_px(1'b0, 24'hFFFFFF, 0, 8'd200, 10'd0, 257, "white_ne");
      run_px(1'b1, 24'hFFFFFF, 0, 8'd200, 10'd0, 202, "white_ee");

      for (int i = 0; i < 256; i++) begin
         wr_pal(i, 24'hFFFFFF);
      end
      run_px(1'b0, 24'h000000, 0, 8'd0, 10'd765, 257, "maxd_ne");
      run_px(1'b1, 24'h000000, 0, 8'd0, 10'd765, 257, "maxd_ee");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
